// File: rtl/cpu_mem_if.sv
// Data-memory bus between the MEM stage (master) and the memory system (slave).
interface cpu_mem_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/cpu_mem.sv
// MEM pipeline stage: issues word loads/stores on the data-memory bus,
// stalls the pipeline while the bus is busy, and drives the MEM/WB register.
// Optional feature: define MEM_TIMEOUT_EN to abort a request after 256
// unacknowledged cycles and raise the sticky bus_err flag.
//
// state | meaning
// IDLE  | no bus transfer; pipeline register follows EX when unstalled
// REQ   | dm_req held high waiting for dm_ack
// DONE  | transfer complete; waiting for the pipeline to advance
module cpu_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_stall,
    input  logic        int_flush,
    input  logic        ex_c_rfw,
    input  logic [1:0]  ex_c_wbsource,
    input  logic [1:0]  ex_c_drw,
    input  logic [31:0] ex_alu_r,
    input  logic [31:0] ex_rfb,
    input  logic [4:0]  ex_rf_waddr,
    input  logic [31:0] ex_jalra,
    cpu_mem_if.master   dm,
    output logic        mem_stall,
    output logic        bus_err,
    output logic        m_c_rfw,
    output logic [4:0]  m_rf_waddr,
    output logic [31:0] m_wdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] rdata_q;
    logic        flush_pend;
    logic        kill_rfw;
    logic        is_access;
    logic        pending;
    logic        kill;
    logic        tmo;
    logic        wb_load;
    logic        wb_zero;
    logic [31:0] load_data;
    logic [31:0] wb_value;
    logic        unused_ok;

`ifdef MEM_TIMEOUT_EN
    logic [7:0]  tmo_cnt;
    logic        bus_err_q;
    assign tmo     = (state == REQ) && !dm.dm_ack && (tmo_cnt == 8'hFF);
    assign bus_err = bus_err_q;
`else
    assign tmo     = 1'b0;
    assign bus_err = 1'b0;
`endif

    // The low address bits never reach the word-aligned bus.
    assign unused_ok = &{1'b0, ex_alu_r[1:0]};

    // A flushed instruction never starts a bus access.
    assign is_access = (ex_c_drw == 2'b10) || (ex_c_drw == 2'b01);
    assign pending   = is_access && !int_flush;
    assign kill      = flush_pend || int_flush;

    // Load data comes from the capture register once the transfer is done.
    assign load_data = (state == DONE) ? rdata_q : dm.dm_rdata;

    // Write-back value selection.
    always_comb begin
        wb_value = 32'h0;
        case (ex_c_wbsource)
            2'd0:    wb_value = ex_alu_r;
            2'd1:    wb_value = load_data;
            2'd2:    wb_value = ex_jalra;
            default: wb_value = 32'h0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state, stall and pipeline-register update controls.
    always_comb begin
        state_nx  = state;
        mem_stall = 1'b0;
        wb_load   = 1'b0;
        wb_zero   = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    mem_stall = 1'b1;
                    state_nx  = REQ;
                end else if (!cpu_stall) begin
                    wb_zero = int_flush;
                    wb_load = !int_flush;
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                if (dm.dm_ack || tmo) begin
                    state_nx = kill ? IDLE : DONE;
                    wb_zero  = kill;
                end
            end
            DONE: begin
                if (!cpu_stall) begin
                    state_nx = IDLE;
                    wb_zero  = int_flush;
                    wb_load  = !int_flush;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Bus request, capture, error tracking and MEM/WB register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dm.dm_req   <= 1'b0;
            dm.dm_we    <= 1'b0;
            dm.dm_addr  <= 32'h0;
            dm.dm_wdata <= 32'h0;
            rdata_q     <= 32'h0;
            flush_pend  <= 1'b0;
            kill_rfw    <= 1'b0;
            m_c_rfw     <= 1'b0;
            m_rf_waddr  <= 5'd0;
            m_wdata     <= 32'h0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt     <= 8'd0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            if (state == IDLE && state_nx == REQ) begin
                dm.dm_req   <= 1'b1;
                dm.dm_we    <= ex_c_drw[0];
                dm.dm_addr  <= {ex_alu_r[31:2], 2'b00};
                dm.dm_wdata <= ex_rfb;
                flush_pend  <= 1'b0;
                kill_rfw    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                tmo_cnt     <= 8'd0;
`endif
            end
            if (state == REQ) begin
                if (int_flush)
                    flush_pend <= 1'b1;
                if (dm.dm_ack) begin
                    dm.dm_req <= 1'b0;
                    if (!dm.dm_we)
                        rdata_q <= dm.dm_rdata;
                end else if (tmo) begin
                    dm.dm_req <= 1'b0;
                    rdata_q   <= 32'hDEADBEEF;
                    kill_rfw  <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                    bus_err_q <= 1'b1;
                end else begin
                    tmo_cnt   <= tmo_cnt + 8'd1;
`endif
                end
            end
            if (wb_zero) begin
                m_c_rfw    <= 1'b0;
                m_rf_waddr <= 5'd0;
                m_wdata    <= 32'h0;
            end else if (wb_load) begin
                m_c_rfw    <= ex_c_rfw && !(state == DONE && kill_rfw);
                m_rf_waddr <= ex_rf_waddr;
                m_wdata    <= wb_value;
            end
        end
    end

endmodule
